// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for the programmable clock divider.
// Master side drives enable and config loads; slave side (the divider) returns clocks and status.
// Optional CLK_DIV_SYNC_EN adds the sync_in phase-realignment request.
interface clock_divider_prog_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             div_load;
  logic [CNT_W-1:0] div_in;
  logic [CNT_W-1:0] high_in;
`ifdef CLK_DIV_SYNC_EN
  logic             sync_in;
`endif
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] div_active;
  logic             cfg_err;

`ifdef CLK_DIV_SYNC_EN
  modport master (
    output en, div_load, div_in, high_in, sync_in,
    input  clk_out, tick, div_active, cfg_err
  );
  modport slave (
    input  en, div_load, div_in, high_in, sync_in,
    output clk_out, tick, div_active, cfg_err
  );
`else
  modport master (
    output en, div_load, div_in, high_in,
    input  clk_out, tick, div_active, cfg_err
  );
  modport slave (
    input  en, div_load, div_in, high_in,
    output clk_out, tick, div_active, cfg_err
  );
`endif
endinterface

// File: rtl/clock_divider_prog.sv
// Programmable clock divider: divided clock + period tick, settings swapped only at period boundaries.
// Latency: all outputs registered, one cycle after the inputs that cause them; no input-to-output paths.
// Backpressure: none; en=0 freezes the divider. Optional macro CLK_DIV_SYNC_EN adds sync_in restart.
module clock_divider_prog #(
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 20,
  parameter int DEF_HIGH = 10
) (
  input  logic                clk_200kHz,
  input  logic                rst_n,
  clock_divider_prog_if.slave bus
);

  localparam logic [CNT_W-1:0] DEF_DIV_C  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_HIGH_C = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO        = CNT_W'(2);
  localparam logic [CNT_W-1:0] ZERO       = '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] pdiv_q, pdiv_d;
  logic [CNT_W-1:0] phigh_q, phigh_d;
  logic             pvld_q, pvld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             sync_req;
  logic             wrap;
  logic             load_ok;

`ifdef CLK_DIV_SYNC_EN
  assign sync_req = bus.sync_in;
`else
  assign sync_req = 1'b0;
`endif

  // div_q >= 2 always holds, so div_q - 1 cannot underflow.
  assign wrap    = (cnt_q == (div_q - ONE));
  assign load_ok = (bus.div_in >= TWO) && (bus.high_in != ZERO) && (bus.high_in < bus.div_in);

  // Next-state: count/wrap/restart, pending-config swap, load capture, then derive clk_out from new state.
  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    high_d  = high_q;
    pdiv_d  = pdiv_q;
    phigh_d = phigh_q;
    pvld_d  = pvld_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;

    if (bus.en) begin
      if (sync_req) begin
        // Phase realignment restarts the period silently (no tick).
        cnt_d = ZERO;
      end else if (wrap) begin
        cnt_d  = ZERO;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
      // A pending config is swapped in only when a new period begins.
      if ((sync_req || wrap) && pvld_q) begin
        div_d  = pdiv_q;
        high_d = phigh_q;
        pvld_d = 1'b0;
      end
    end

    // Capture after the swap so a load in the boundary cycle waits for the next boundary.
    if (bus.div_load) begin
      if (load_ok) begin
        pdiv_d  = bus.div_in;
        phigh_d = bus.high_in;
        pvld_d  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    clk_d = (cnt_d < high_d);
  end

  // State registers; reset restores the default config and drops any pending one.
  always_ff @(posedge clk_200kHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= ZERO;
      div_q   <= DEF_DIV_C;
      high_q  <= DEF_HIGH_C;
      pdiv_q  <= ZERO;
      phigh_q <= ZERO;
      pvld_q  <= 1'b0;
      clk_q   <= 1'b1;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      high_q  <= high_d;
      pdiv_q  <= pdiv_d;
      phigh_q <= phigh_d;
      pvld_q  <= pvld_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign bus.clk_out    = clk_q;
  assign bus.tick       = tick_q;
  assign bus.div_active = div_q;
  assign bus.cfg_err    = err_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: directed stimulus pushes per-cycle expected outputs into a queue,
// an independent monitor pops and compares them each cycle on the falling edge.
// Build with CLK_DIV_SYNC_EN defined to also exercise the sync_in restart.
module tb_clock_divider_prog;

  logic clk;
  logic rst_n;

  clock_divider_prog_if #(.CNT_W(16)) bus ();

  clock_divider_prog #(.CNT_W(16), .DEF_DIV(20), .DEF_HIGH(10)) dut (
    .clk_200kHz (clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        clk_out;
    logic        tick;
    int          dact;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Expected counter state tracked by the stimulus (spec-level period/high description).
  int e_cnt  = 0;
  int e_div  = 20;
  int e_high = 10;

  task automatic chk(input string name, input int act, input int exp_v, input int unsigned at);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, at, act, exp_v);
  endtask

  // Monitor: compare whatever expectation is due this cycle against the DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("stale_expectation", 1, 0, e.cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("clk_out",    int'(bus.clk_out),    int'(e.clk_out), cyc);
        chk("tick",       int'(bus.tick),       int'(e.tick),    cyc);
        chk("div_active", int'(bus.div_active), e.dact,          cyc);
        chk("cfg_err",    int'(bus.cfg_err),    int'(e.err),     cyc);
      end
    end
  end

  // One cycle of stimulus; expected outputs are due after the next rising edge.
  task automatic drive(input logic en_v, input logic ld, input int dv, input int hv, input logic sy,
                       input logic ec, input logic et, input int ed, input logic ee);
    exp_t e;
    e.cyc     = cyc + 1;
    e.clk_out = ec;
    e.tick    = et;
    e.dact    = ed;
    e.err     = ee;
    q.push_back(e);
    bus.en       = en_v;
    bus.div_load = ld;
    bus.div_in   = dv[15:0];
    bus.high_in  = hv[15:0];
`ifdef CLK_DIV_SYNC_EN
    bus.sync_in  = sy;
`else
    if (sy) $display("sync request ignored in this build");
`endif
    @(negedge clk);
  endtask

  // Plain counting under the current config, no loads.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      e_cnt = (e_cnt == e_div - 1) ? 0 : e_cnt + 1;
      drive(1'b1, 1'b0, 0, 0, 1'b0, (e_cnt < e_high), (e_cnt == 0), e_div, 1'b0);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;
    bus.high_in  = '0;
`ifdef CLK_DIV_SYNC_EN
    bus.sync_in  = 1'b0;
`endif
    @(negedge clk);

    // Reset state held regardless of en.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 20, 1'b0);

    // Defaults: 10 high / 10 low, tick every 20.
    rst_n = 1'b1;
    e_cnt = 0; e_div = 20; e_high = 10;
    run(24);                                    // cnt = 4

    // en low for 7 cycles at cnt=4: frozen high, no tick; resumes at 5.
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 20, 1'b0);
    run(1);                                     // cnt = 5

    // Load 8/2 mid-period: current 20-cycle period completes first.
    e_cnt = 6;
    drive(1'b1, 1'b1, 8, 2, 1'b0, 1'b1, 1'b0, 20, 1'b0);
    run(13);                                    // cnt = 19
    e_div = 8; e_high = 2; e_cnt = 0;
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 8, 1'b0);
    run(16);                                    // cnt = 0

    // Rejected loads: div=1, high=0, high==div. Each gives one cfg_err pulse.
    e_cnt = 1; drive(1'b1, 1'b1, 1, 1, 1'b0, 1'b1, 1'b0, 8, 1'b1);
    e_cnt = 2; drive(1'b1, 1'b1, 6, 0, 1'b0, 1'b0, 1'b0, 8, 1'b1);
    e_cnt = 3; drive(1'b1, 1'b1, 6, 6, 1'b0, 1'b0, 1'b0, 8, 1'b1);
    run(13);                                    // cnt = 0, period still 8

    // Two loads before a boundary: only the last (40/30) takes effect.
    e_cnt = 1; drive(1'b1, 1'b1, 10, 5, 1'b0, 1'b1, 1'b0, 8, 1'b0);
    e_cnt = 2; drive(1'b1, 1'b1, 40, 30, 1'b0, 1'b0, 1'b0, 8, 1'b0);
    run(5);                                     // cnt = 7
    e_div = 40; e_high = 30; e_cnt = 0;
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 40, 1'b0);
    run(45);                                    // cnt = 5
    run(34);                                    // cnt = 39

    // Load in the wrap cycle: not applied at this boundary, only at the next.
    e_cnt = 0;
    drive(1'b1, 1'b1, 4, 1, 1'b0, 1'b1, 1'b1, 40, 1'b0);
    run(39);                                    // cnt = 39
    e_div = 4; e_high = 1; e_cnt = 0;
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 4, 1'b0);
    run(6);                                     // cnt = 2

    // Reset mid-period with a pending config: defaults resume, pending discarded.
    e_cnt = 3;
    drive(1'b1, 1'b1, 12, 3, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 20, 1'b0);
    rst_n = 1'b1;
    e_cnt = 0; e_div = 20; e_high = 10;
    run(25);                                    // cnt = 5

`ifdef CLK_DIV_SYNC_EN
    // Sync at cnt=13: restart high with no tick, next tick 20 cycles later.
    run(8);                                     // cnt = 13
    e_cnt = 0;
    drive(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 20, 1'b0);
    run(25);
`endif

    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL leftover_expectations actual=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
